checker_keyfsm: RTL and testbench
=================================

CHECKER_KEYFSM -- requirements
Module: checker_keyfsm

Interface
REQ-001 SHALL take parameter W, default 10: width of input word x.
REQ-002 SHALL take parameter STAGES, default 4, legal 1..8: number of words in the checked sequence.
REQ-003 SHALL take parameter PATTERN, default {10'h2AA,10'h155,10'h0F0,10'h3A5}, STAGES*W bits: expected words, with word i at bits [i*W +: W].
REQ-004 SHALL take parameter LOCK_KEY, default 4'b1011, STAGES bits: correct unlock key.
REQ-005 clk  input  1  clock, all logic on posedge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 x_valid  input  1  x is presented this cycle.
REQ-008 x  input  W  data word.
REQ-009 keyinput  input  STAGES  lock key, sampled at each branch, never latched.
REQ-010 match  output  1  registered one-cycle pulse: sequence completed on the genuine path.
REQ-011 err  output  1  registered one-cycle pulse: mismatch, or sequence completed on the decoy path.
REQ-012 busy  output  1  registered, high while a sequence is in progress.
REQ-013 stage  output  3  registered index of the next expected word (0 in IDLE).
REQ-014 match_cnt  output  8  registered, saturating count of match pulses.

Function
REQ-015 State SHALL be {path, idx}, with path in {G,D} and idx 0..STAGES-1; IDLE SHALL be idx=0.
REQ-016 Without x_valid, state SHALL hold; match and err SHALL be 0 next cycle.
REQ-017 In IDLE, when x_valid and x≠PATTERN[0], the block SHALL stay in IDLE with no err.
REQ-018 In IDLE, when x_valid and x==PATTERN[0], the block SHALL go to idx=1 with path = G if keyinput[0]==LOCK_KEY[0], else D.
REQ-019 At idx i≥1, when x_valid and x==PATTERN[i] and i<STAGES-1: idx SHALL become i+1, and path SHALL become D if path==D or keyinput[i]≠LOCK_KEY[i]; path SHALL never return from D to G within a sequence.
REQ-020 At the final word (i==STAGES-1) with a match, with keyinput[i] applied per REQ-019: the block SHALL return to IDLE; the final path G SHALL pulse match next cycle, and D SHALL pulse err.
REQ-021 At idx≥1, when x_valid and x≠PATTERN[idx], the block SHALL return to IDLE and pulse err next cycle, on both paths.
REQ-022 For STAGES==1, a matching word in IDLE SHALL complete immediately per REQ-020 using keyinput[0].
REQ-023 busy and stage SHALL depend on idx only, so G and D are indistinguishable until the completion pulse.
REQ-024 match_cnt SHALL increment on each match pulse and saturate at 255, without wrapping.
REQ-025 Latency: one cycle from the accepting clk edge to the match or err pulse; match and err SHALL never be high together.
REQ-026 A key change mid-sequence SHALL affect only the branches taken after the change.

Reset
REQ-027 While rst is high at posedge clk, the block SHALL enter IDLE(G) with match=0, err=0, busy=0, stage=0, match_cnt=0; rst SHALL override any x_valid in the same cycle.
REQ-028 Reset mid-sequence SHALL abandon the sequence without an err pulse.

Structure
REQ-029 The path enum {G,D} and a pattern-word extraction function SHALL live in a shared package checker_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the comparator SHALL be inline.
REQ-031 An assertion SHALL fire if STAGES lies outside 1..8 or PATTERN/LOCK_KEY widths do not match STAGES*W and STAGES.

Verification (defaults; correct key = 4'b1011)
REQ-032 rst, then 3A5,0F0,155,2AA on consecutive cycles with key 1011 -> match pulse one cycle after 2AA; match_cnt=1; stage runs 1,2,3,0.
REQ-033 Same words with key 1111 (bit2 wrong) -> err pulse after 2AA, no match, match_cnt=0; busy and stage identical to REQ-032.
REQ-034 3A5, 0F0, then 000 -> err pulse after 000; IDLE; stage=0.
REQ-035 3A5, 0F0, then rst for one cycle, then 155 -> no err, 155 ignored in IDLE, all outputs 0.
REQ-036 3A5 with x_valid gaps of 5 idle cycles between words, key 1011 -> state holds during gaps, match after 2AA.
REQ-037 260 genuine sequences -> match_cnt=255 after the 255th and stays 255.

Source files
------------

// File: rtl/checker_pkg.sv
// Shared types and helpers for the key-gated sequence checker.
// Pure definitions, no state; no latency.
// No flow control involved.
package checker_pkg;

   // Path taken through a sequence: genuine (key bits all correct so far) or decoy.
   typedef enum logic {
      PATH_G = 1'b0,
      PATH_D = 1'b1
   } path_e;

   // Widest pattern the extraction helper can carry (8 words of up to 32 bits).
   localparam int PAT_MAX = 256;

   // Return pattern word idx (word i lives at bits [i*w +: w]), zero-extended.
   function automatic logic [PAT_MAX-1:0] pat_word(input logic [PAT_MAX-1:0] pat,
                                                   input logic [2:0]         idx,
                                                   input logic [5:0]         w);
      logic [8:0]         sh;
      logic [PAT_MAX-1:0] mask;
      sh   = 9'(idx) * 9'(w);
      mask = (PAT_MAX'(1) << w) - PAT_MAX'(1);
      return (pat >> sh) & mask;
   endfunction

endpackage

// File: rtl/checker_keyfsm.sv
// Sequence checker: words must arrive in PATTERN order; per-branch key bits pick genuine or decoy path.
// Latency: match/err pulse one cycle after the accepting edge; busy/stage update on the same edge.
// No backpressure: x is consumed whenever x_valid is high, state holds otherwise.
module checker_keyfsm
   import checker_pkg::*;
#(
   parameter int                    W        = 10,
   parameter int                    STAGES   = 4,
   parameter logic [STAGES*W-1:0]   PATTERN  = {10'h2AA, 10'h155, 10'h0F0, 10'h3A5},
   parameter logic [STAGES-1:0]     LOCK_KEY = 4'b1011
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              x_valid,
   input  logic [W-1:0]      x,
   input  logic [STAGES-1:0] keyinput,
   output logic              match,
   output logic              err,
   output logic              busy,
   output logic [2:0]        stage,
   output logic [7:0]        match_cnt
);

   localparam int         IW   = (STAGES > 1) ? $clog2(STAGES) : 1;
   localparam logic [2:0] LAST = 3'(STAGES - 1);
   localparam logic [5:0] W6   = 6'(W);

   // Reject configurations the datapath cannot represent.
   if (STAGES < 1 || STAGES > 8 || W < 1 || W > 32 ||
       $bits(PATTERN) != STAGES * W || $bits(LOCK_KEY) != STAGES) begin : g_bad_cfg
      $error("checker_keyfsm: illegal STAGES/W/PATTERN/LOCK_KEY configuration");
   end

   path_e        r_path;
   logic [2:0]   r_idx;
   logic         r_match;
   logic         r_err;
   logic         r_busy;
   logic [7:0]   r_cnt;

   logic [PAT_MAX-1:0] w_exp_full;
   logic [W-1:0]       w_exp;
   logic [IW-1:0]      w_kidx;
   logic               w_hit;
   logic               w_key_ok;
   path_e              w_next_path;

   // Expected word for the current index and the key bit that steers this branch.
   assign w_exp_full  = pat_word(PAT_MAX'(PATTERN), r_idx, W6);
   assign w_exp       = w_exp_full[W-1:0];
   assign w_kidx      = r_idx[IW-1:0];
   assign w_hit       = (x == w_exp);
   assign w_key_ok    = (keyinput[w_kidx] == LOCK_KEY[w_kidx]);
   // Once on the decoy path a sequence can never get back to genuine.
   assign w_next_path = ((r_idx != 3'd0 && r_path == PATH_D) || !w_key_ok) ? PATH_D : PATH_G;

   // Sequence FSM with registered pulses, progress flag and saturating match counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_path  <= PATH_G;
         r_idx   <= 3'd0;
         r_match <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_match <= 1'b0;
         r_err   <= 1'b0;
         if (x_valid) begin
            if (w_hit) begin
               if (r_idx == LAST) begin
                  r_idx  <= 3'd0;
                  r_path <= PATH_G;
                  r_busy <= 1'b0;
                  if (w_next_path == PATH_G) begin
                     r_match <= 1'b1;
                     if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                     end
                  end else begin
                     r_err <= 1'b1;
                  end
               end else begin
                  r_idx  <= r_idx + 3'd1;
                  r_path <= w_next_path;
                  r_busy <= 1'b1;
               end
            end else begin
               // A stray word in IDLE is simply ignored; mid-sequence it aborts with err.
               r_err  <= (r_idx != 3'd0);
               r_idx  <= 3'd0;
               r_path <= PATH_G;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign match     = r_match;
   assign err       = r_err;
   assign busy      = r_busy;
   assign stage     = r_idx;
   assign match_cnt = r_cnt;

endmodule

// File: tb/tb_checker_keyfsm.sv
// Scoreboard bench for checker_keyfsm with default parameters.
// Stimulus pushes the hand-computed expected outputs per cycle; a monitor pops and compares.
// No backpressure in the DUT; the monitor samples 1 time unit after each rising edge.
module tb_checker_keyfsm;

   typedef struct {
      int         step;
      logic       m;
      logic       e;
      logic       b;
      logic [2:0] s;
      logic [7:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       x_valid = 1'b0;
   logic [9:0] x = 10'h000;
   logic [3:0] keyinput = 4'b0000;
   logic       match;
   logic       err;
   logic       busy;
   logic [2:0] stage;
   logic [7:0] match_cnt;

   int   checks = 0;
   int   failures = 0;
   int   step_no = 0;
   exp_t q[$];

   localparam logic [9:0] P0 = 10'h3A5;
   localparam logic [9:0] P1 = 10'h0F0;
   localparam logic [9:0] P2 = 10'h155;
   localparam logic [9:0] P3 = 10'h2AA;
   localparam logic [3:0] KOK = 4'b1011;

   checker_keyfsm dut (
      .clk       (clk),
      .rst       (rst),
      .x_valid   (x_valid),
      .x         (x),
      .keyinput  (keyinput),
      .match     (match),
      .err       (err),
      .busy      (busy),
      .stage     (stage),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int step, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, want);
      end
   endtask

   // One cycle of stimulus plus the outputs expected right after the next rising edge.
   task automatic cyc(input logic r, input logic v, input logic [9:0] xw, input logic [3:0] k,
                      input logic em, input logic ee, input logic eb, input logic [2:0] es,
                      input logic [7:0] ec);
      exp_t t;
      @(negedge clk);
      rst      = r;
      x_valid  = v;
      x        = xw;
      keyinput = k;
      step_no++;
      t.step = step_no;
      t.m = em; t.e = ee; t.b = eb; t.s = es; t.c = ec;
      q.push_back(t);
   endtask

   task automatic do_reset();
      cyc(1'b1, 1'b0, 10'h000, KOK, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0);
   endtask

   task automatic idle(input int n, input logic eb, input logic [2:0] es, input logic [7:0] ec);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 10'h000, KOK, 1'b0, 1'b0, eb, es, ec);
   endtask

   // Monitor: compare every cycle's outputs against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("match", e.step, int'(match), int'(e.m));
            chk("err", e.step, int'(err), int'(e.e));
            chk("busy", e.step, int'(busy), int'(e.b));
            chk("stage", e.step, int'(stage), int'(e.s));
            chk("match_cnt", e.step, int'(match_cnt), int'(e.c));
            if (match || err) chk("match_err_exclusive", e.step, int'(match & err), 0);
         end
      end
   end

   initial begin
      int n;
      // Genuine sequence, back to back.
      do_reset();
      cyc(0, 1, P0, KOK, 0, 0, 1, 3'd1, 8'd0);
      cyc(0, 1, P1, KOK, 0, 0, 1, 3'd2, 8'd0);
      cyc(0, 1, P2, KOK, 0, 0, 1, 3'd3, 8'd0);
      cyc(0, 1, P3, KOK, 1, 0, 0, 3'd0, 8'd1);
      idle(2, 0, 3'd0, 8'd1);

      // Wrong key bit 2: decoy path completes with err, identical busy/stage.
      do_reset();
      cyc(0, 1, P0, 4'b1111, 0, 0, 1, 3'd1, 8'd0);
      cyc(0, 1, P1, 4'b1111, 0, 0, 1, 3'd2, 8'd0);
      cyc(0, 1, P2, 4'b1111, 0, 0, 1, 3'd3, 8'd0);
      cyc(0, 1, P3, 4'b1111, 0, 1, 0, 3'd0, 8'd0);
      idle(1, 0, 3'd0, 8'd0);

      // Wrong word mid-sequence aborts with err.
      cyc(0, 1, P0, KOK, 0, 0, 1, 3'd1, 8'd0);
      cyc(0, 1, P1, KOK, 0, 0, 1, 3'd2, 8'd0);
      cyc(0, 1, 10'h000, KOK, 0, 1, 0, 3'd0, 8'd0);
      idle(1, 0, 3'd0, 8'd0);

      // Stray words in IDLE are ignored without err.
      cyc(0, 1, P1, KOK, 0, 0, 0, 3'd0, 8'd0);
      cyc(0, 1, 10'h3FF, 4'b0000, 0, 0, 0, 3'd0, 8'd0);

      // Reset mid-sequence: no err, following word ignored in IDLE.
      cyc(0, 1, P0, KOK, 0, 0, 1, 3'd1, 8'd0);
      cyc(0, 1, P1, KOK, 0, 0, 1, 3'd2, 8'd0);
      do_reset();
      cyc(0, 1, P2, KOK, 0, 0, 0, 3'd0, 8'd0);
      idle(1, 0, 3'd0, 8'd0);

      // Reset overrides a valid first word in the same cycle.
      cyc(1, 1, P0, KOK, 0, 0, 0, 3'd0, 8'd0);

      // Gaps of 5 idle cycles: state holds, match after the last word.
      cyc(0, 1, P0, KOK, 0, 0, 1, 3'd1, 8'd0);
      idle(5, 1, 3'd1, 8'd0);
      cyc(0, 1, P1, KOK, 0, 0, 1, 3'd2, 8'd0);
      idle(5, 1, 3'd2, 8'd0);
      cyc(0, 1, P2, KOK, 0, 0, 1, 3'd3, 8'd0);
      idle(5, 1, 3'd3, 8'd0);
      cyc(0, 1, P3, KOK, 1, 0, 0, 3'd0, 8'd1);
      idle(1, 0, 3'd0, 8'd1);

      // Bit 1 wrong only at its branch, correct afterwards: still decoy.
      cyc(0, 1, P0, KOK,     0, 0, 1, 3'd1, 8'd1);
      cyc(0, 1, P1, 4'b1001, 0, 0, 1, 3'd2, 8'd1);
      cyc(0, 1, P2, KOK,     0, 0, 1, 3'd3, 8'd1);
      cyc(0, 1, P3, KOK,     0, 1, 0, 3'd0, 8'd1);

      // Key wrong only in bits not yet used, fixed before they are used: genuine.
      cyc(0, 1, P0, 4'b1111, 0, 0, 1, 3'd1, 8'd1);
      cyc(0, 1, P1, 4'b1111, 0, 0, 1, 3'd2, 8'd1);
      cyc(0, 1, P2, KOK,     0, 0, 1, 3'd3, 8'd1);
      cyc(0, 1, P3, KOK,     1, 0, 0, 3'd0, 8'd2);

      // Wrong bit 0 at the first branch: decoy, err on last word.
      cyc(0, 1, P0, 4'b1010, 0, 0, 1, 3'd1, 8'd2);
      cyc(0, 1, P1, KOK,     0, 0, 1, 3'd2, 8'd2);
      cyc(0, 1, P2, KOK,     0, 0, 1, 3'd3, 8'd2);
      cyc(0, 1, P3, KOK,     0, 1, 0, 3'd0, 8'd2);

      // Decoy path aborted by a wrong word also pulses err.
      cyc(0, 1, P0, 4'b0000, 0, 0, 1, 3'd1, 8'd2);
      cyc(0, 1, P2, KOK,     0, 1, 0, 3'd0, 8'd2);

      // Saturation: 260 genuine sequences after reset.
      do_reset();
      for (int s = 1; s <= 260; s++) begin
         n = (s > 255) ? 255 : s;
         cyc(0, 1, P0, KOK, 0, 0, 1, 3'd1, 8'(n - 1 > 255 ? 255 : (s > 255 ? 255 : s - 1)));
         cyc(0, 1, P1, KOK, 0, 0, 1, 3'd2, 8'(s > 255 ? 255 : s - 1));
         cyc(0, 1, P2, KOK, 0, 0, 1, 3'd3, 8'(s > 255 ? 255 : s - 1));
         cyc(0, 1, P3, KOK, 1, 0, 0, 3'd0, 8'(n));
      end
      idle(2, 0, 3'd0, 8'd255);

      // Drain the scoreboard with a bounded wait.
      for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
      @(posedge clk);
      #2;
      chk("scoreboard_drained", step_no, q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
